perf_ctrl: RTL and testbench
============================

# perf_ctrl

Sequencer and SPR-mapped control/readout front end for a bank of `perf_ex_insn_count`-style 64-bit performance counters in the or1200 core. It turns software start/stop commands (or a programmed cycle window) into single-cycle `perf_start`/`perf_end` pulses and per-counter enables. It returns each counter's latched 64-bit `total_count` over a 32-bit register port, with a tear-free high-half shadow.

## Interface
Parameters:
- NUM_CNT, 4, number of attached counters (1..8)
- IDX_W, 2, width of counter select, = clog2(NUM_CNT), min 1

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset (`OR1200_RST_EVENT`/`OR1200_RST_VALUE` = posedge/1)
- spr_cs  in  1  register access strobe, one cycle per access
- spr_we  in  1  1 = write, 0 = read
- spr_addr  in  3  register select
- spr_dat_i  in  32  write data
- spr_dat_o  out  32  read data, valid with spr_ack
- spr_ack  out  1  access acknowledge
- total_count_i  in  NUM_CNT*64  counter results; counter k at bits [64k+63:64k]
- perf_start  out  1  clear pulse to all counters
- perf_end  out  1  latch pulse to all counters
- cnt_en  out  NUM_CNT  per-counter count enable
- busy  out  1  FSM in START/RUN/STOP/SETTLE
- done  out  1  results valid (DONE state)
- irq  out  1  completion interrupt, level

## Operation
Registers (spr_addr):
- 0 CTRL (W): bit0 start, bit1 stop, bit2 irq_en (stored), bit3 irq_clr, bits[8+NUM_CNT-1:8] enable mask (stored). Read returns stored irq_en/mask.
- 1 STATUS (R): bit0 busy, bit1 done, bit2 irq, bits[6:4] FSM state code.
- 2 WINDOW (R/W): 32-bit run length in cycles; 0 = unlimited.
- 3 SEL (R/W): counter index, bits[IDX_W-1:0]; values >= NUM_CNT read back as zero data.
- 4 DATA_LO (R): total_count_i[SEL][31:0]; same cycle, [63:32] is copied into hi_shadow.
- 5 DATA_HI (R): hi_shadow.
- 6,7: read 0, writes ignored.

FSM states and codes: IDLE 0, START 1, RUN 2, STOP 3, SETTLE 4, DONE 5.
- IDLE/DONE -> START on a CTRL write with start=1 and stop=0. Re-entering START clears done and irq.
- START: perf_start=1 for exactly one cycle, cnt_en=0. Clears the 32-bit elapsed counter. Next state RUN.
- RUN: cnt_en=mask. Elapsed increments each cycle. Go to STOP on a stop write, or when WINDOW!=0 and elapsed==WINDOW-1 (RUN lasts exactly WINDOW cycles).
- STOP: perf_end=1 for one cycle, cnt_en=0. Next state SETTLE.
- SETTLE: one cycle, so the counters' total_count register is updated. Next state DONE.
- DONE: done=1. irq is set on entry if irq_en=1, and held until irq_clr or start.
- A start write while busy is ignored. A stop write outside RUN is ignored. start+stop in the same write: stop wins, start ignored.
- The mask and WINDOW may be written at any time. A mask change takes effect on cnt_en the next cycle. A WINDOW change during RUN is compared live; if the new WINDOW-1 is <= elapsed, RUN continues until stop (no wrap past 2^32-1; elapsed saturates).
- Reset mid-run: all outputs drop immediately to reset values and the FSM goes to IDLE. Counters keep their own state.

## Timing
- Reset values: spr_dat_o=0, spr_ack=0, perf_start=0, perf_end=0, cnt_en=0, busy=0, done=0, irq=0. Stored: mask=0, irq_en=0, WINDOW=0, SEL=0, hi_shadow=0, elapsed=0, state=IDLE.
- All outputs are registered.
- spr_ack pulses one cycle after spr_cs, for reads and writes; spr_dat_o is valid in that cycle and is 0 otherwise.
- Start write accepted at cycle T: perf_start high T+1, cnt_en high T+2..T+1+W, perf_end high T+2+W, done high from T+4+W.
- Back-to-back accesses (spr_cs every cycle) are supported with no stalls.

## Structure
- perf_ctrl_pkg (include file `perf_ctrl_defines.v`): register address constants, CTRL bit positions, FSM state encodings.
- One sub-module: perf_ctrl_readmux. It holds the SEL-indexed 64-bit mux of total_count_i plus the hi_shadow register. FSM and register file stay in perf_ctrl.

## Test plan
- Reset, then read all regs -> all read 0; outputs at reset values; spr_ack 1 cycle after each cs.
- mask=0x5, WINDOW=10, start -> perf_start one pulse; cnt_en=0x5 for exactly 10 cycles; perf_end pulse 1 cycle later; done 2 cycles after perf_end.
- WINDOW=0, irq_en=1, start, stop after 100 cycles -> irq=1 in DONE; stays high until irq_clr write, then 0.
- total_count_i[2]=0x0000_0001_FFFF_FFFF, SEL=2: read LO -> 0xFFFF_FFFF; change input to 0x2_0000_0000; read HI -> 0x1 (shadow).
- start+stop in one write from IDLE -> no perf_start. Start during RUN -> ignored. Stop in DONE -> ignored.
- Assert rst during RUN -> cnt_en, busy, done drop in the same cycle; FSM reads IDLE after release.

Source files
------------

// File: rtl/perf_ctrl_pkg.sv
// Shared constants for the performance-counter sequencer: register map,
// CTRL bit positions and FSM state encodings.
package perf_ctrl_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_WINDOW  = 3'd2;
    localparam logic [2:0] ADDR_SEL     = 3'd3;
    localparam logic [2:0] ADDR_DATA_LO = 3'd4;
    localparam logic [2:0] ADDR_DATA_HI = 3'd5;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_IRQ_CLR  = 3;
    localparam int CTRL_MASK_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_STOP   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_START) || (s == ST_RUN) || (s == ST_STOP) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/perf_ctrl_readmux.sv
// Selects one counter's 64-bit total and keeps the upper half in a shadow
// register so a LO-then-HI read pair is tear-free.
module perf_ctrl_readmux
    import perf_ctrl_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int IDX_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CNT*64-1:0]   total_count_i,
    input  logic [IDX_W-1:0]        i_sel,
    input  logic                    i_shadow_ld,
    output logic [31:0]             o_data_lo,
    output logic [31:0]             o_data_hi
);

    logic [63:0] w_sel_data;
    logic [31:0] r_hi_shadow;

    // Indices with no attached counter fall through to zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (i_sel == IDX_W'(k)) w_sel_data = total_count_i[64*k +: 64];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_hi_shadow <= '0;
        else if (i_shadow_ld) r_hi_shadow <= w_sel_data[63:32];
    end

    assign o_data_lo = w_sel_data[31:0];
    assign o_data_hi = r_hi_shadow;

endmodule

// File: rtl/perf_ctrl.sv
// Start/stop/window sequencer for a bank of 64-bit performance counters,
// with a small register port for control and result readout.
//   state  | meaning
//   IDLE   | waiting for start
//   START  | perf_start pulse, elapsed cleared
//   RUN    | counters enabled by mask
//   STOP   | perf_end pulse
//   SETTLE | counters latch total_count
//   DONE   | results valid, optional irq
module perf_ctrl
    import perf_ctrl_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int IDX_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spr_cs,
    input  logic                    spr_we,
    input  logic [2:0]              spr_addr,
    input  logic [31:0]             spr_dat_i,
    output logic [31:0]             spr_dat_o,
    output logic                    spr_ack,
    input  logic [NUM_CNT*64-1:0]   total_count_i,
    output logic                    perf_start,
    output logic                    perf_end,
    output logic [NUM_CNT-1:0]      cnt_en,
    output logic                    busy,
    output logic                    done,
    output logic                    irq
);

    state_t               r_state, w_state_nxt;
    logic [NUM_CNT-1:0]   r_mask, w_mask_nxt;
    logic                 r_irq_en;
    logic [31:0]          r_window, r_elapsed;
    logic [IDX_W-1:0]     r_sel;
    logic                 w_wr, w_rd, w_ctrl_wr, w_start_cmd, w_stop_cmd, w_irq_clr, w_win_hit;
    logic [31:0]          w_rd_data, w_ctrl_rd, w_data_lo, w_data_hi;

    assign w_wr        = spr_cs & spr_we;
    assign w_rd        = spr_cs & ~spr_we;
    assign w_ctrl_wr   = w_wr && (spr_addr == ADDR_CTRL);
    assign w_start_cmd = w_ctrl_wr && spr_dat_i[CTRL_START] && !spr_dat_i[CTRL_STOP];
    assign w_stop_cmd  = w_ctrl_wr && spr_dat_i[CTRL_STOP];
    assign w_irq_clr   = w_ctrl_wr && spr_dat_i[CTRL_IRQ_CLR];
    assign w_mask_nxt  = w_ctrl_wr ? spr_dat_i[CTRL_MASK_LSB +: NUM_CNT] : r_mask;
    assign w_win_hit   = (r_window != 32'd0) && (r_elapsed == r_window - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask   <= '0;
            r_irq_en <= 1'b0;
            r_window <= '0;
            r_sel    <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_mask   <= w_mask_nxt;
                r_irq_en <= spr_dat_i[CTRL_IRQ_EN];
            end
            if (w_wr && spr_addr == ADDR_WINDOW) r_window <= spr_dat_i;
            if (w_wr && spr_addr == ADDR_SEL)    r_sel    <= spr_dat_i[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_cmd) w_state_nxt = ST_START;
            ST_START:         w_state_nxt = ST_RUN;
            ST_RUN:           if (w_stop_cmd || w_win_hit) w_state_nxt = ST_STOP;
            ST_STOP:          w_state_nxt = ST_SETTLE;
            ST_SETTLE:        w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // Saturating so a shrunk WINDOW never wraps back into a match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        r_elapsed <= '0;
        else if (r_state == ST_START)                   r_elapsed <= '0;
        else if (r_state == ST_RUN && r_elapsed != '1)  r_elapsed <= r_elapsed + 32'd1;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_start <= 1'b0;
            perf_end   <= 1'b0;
            cnt_en     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            irq        <= 1'b0;
        end else begin
            perf_start <= (w_state_nxt == ST_START);
            perf_end   <= (w_state_nxt == ST_STOP);
            cnt_en     <= (w_state_nxt == ST_RUN) ? w_mask_nxt : '0;
            busy       <= is_busy(w_state_nxt);
            done       <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_DONE && r_state != ST_DONE && r_irq_en) irq <= 1'b1;
            else if (w_irq_clr || w_state_nxt == ST_START)                 irq <= 1'b0;
        end
    end

    always_comb begin
        w_ctrl_rd = '0;
        w_ctrl_rd[CTRL_IRQ_EN] = r_irq_en;
        w_ctrl_rd[CTRL_MASK_LSB +: NUM_CNT] = r_mask;
    end

    always_comb begin
        w_rd_data = '0;
        case (spr_addr)
            ADDR_CTRL:    w_rd_data = w_ctrl_rd;
            ADDR_STATUS:  w_rd_data = {25'd0, r_state, 1'b0, irq, done, busy};
            ADDR_WINDOW:  w_rd_data = r_window;
            ADDR_SEL:     w_rd_data = 32'(r_sel);
            ADDR_DATA_LO: w_rd_data = w_data_lo;
            ADDR_DATA_HI: w_rd_data = w_data_hi;
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_dat_o <= '0;
            spr_ack   <= 1'b0;
        end else begin
            spr_dat_o <= w_rd ? w_rd_data : '0;
            spr_ack   <= spr_cs;
        end
    end

    perf_ctrl_readmux #(
        .NUM_CNT (NUM_CNT),
        .IDX_W   (IDX_W)
    ) u_readmux (
        .clk           (clk),
        .rst           (rst),
        .total_count_i (total_count_i),
        .i_sel         (r_sel),
        .i_shadow_ld   (w_rd && spr_addr == ADDR_DATA_LO),
        .o_data_lo     (w_data_lo),
        .o_data_hi     (w_data_hi)
    );

endmodule

// File: tb/tb_perf_ctrl.sv
// Directed bench for perf_ctrl: register map, windowed and manual runs,
// irq handling, shadowed readout and reset during a run.
module tb_perf_ctrl;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spr_cs = 1'b0;
    logic          spr_we = 1'b0;
    logic [2:0]    spr_addr = '0;
    logic [31:0]   spr_dat_i = '0;
    logic [31:0]   spr_dat_o;
    logic          spr_ack;
    logic [255:0]  tc = '0;
    logic          perf_start, perf_end, busy, done, irq;
    logic [3:0]    cnt_en;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    perf_ctrl #(.NUM_CNT(4), .IDX_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .spr_cs        (spr_cs),
        .spr_we        (spr_we),
        .spr_addr      (spr_addr),
        .spr_dat_i     (spr_dat_i),
        .spr_dat_o     (spr_dat_o),
        .spr_ack       (spr_ack),
        .total_count_i (tc),
        .perf_start    (perf_start),
        .perf_end      (perf_end),
        .cnt_en        (cnt_en),
        .busy          (busy),
        .done          (done),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic spr_write(input logic [2:0] a, input logic [31:0] d);
        spr_cs = 1'b1; spr_we = 1'b1; spr_addr = a; spr_dat_i = d;
        step();
        spr_cs = 1'b0; spr_we = 1'b0;
        chk("wr_ack", spr_ack, 1);
    endtask

    task automatic spr_read(input logic [2:0] a, output logic [31:0] d);
        spr_cs = 1'b1; spr_we = 1'b0; spr_addr = a;
        step();
        spr_cs = 1'b0;
        chk("rd_ack", spr_ack, 1);
        d = spr_dat_o;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {spr_ack, perf_start, perf_end, cnt_en, busy, done, irq}, 0);
        chk("rst_dat", spr_dat_o, 0);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            spr_read(3'(a), rd);
            chk($sformatf("rst_reg%0d", a), rd, 0);
        end
        step();
        chk("ack_idle", {spr_ack, spr_dat_o}, 0);

        // windowed run: mask 0x5, WINDOW 10
        spr_write(3'd2, 32'd10);
        spr_read(3'd2, rd);
        chk("window_rb", rd, 10);
        spr_write(3'd0, 32'h501);
        chk("w_pstart", perf_start, 1);
        chk("w_cnten0", cnt_en, 0);
        chk("w_busy", busy, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("w_run%0d", i), {perf_start, perf_end, cnt_en}, 6'h05);
            step();
        end
        chk("w_pend", {perf_end, cnt_en}, 5'h10);
        step();
        chk("w_settle", {perf_end, done, busy}, 3'b001);
        step();
        chk("w_done", {done, busy, irq}, 3'b100);
        spr_read(3'd1, rd);
        chk("w_status", rd, 32'h52);
        spr_read(3'd0, rd);
        chk("ctrl_rb", rd, 32'h500);

        // stop in DONE is ignored
        spr_write(3'd0, 32'h502);
        chk("done_stop", {perf_end, done, busy}, 3'b010);

        // unlimited run with irq, manual stop
        spr_write(3'd2, 32'd0);
        spr_write(3'd0, 32'h505);
        chk("m_pstart", {perf_start, done}, 2'b10);
        repeat (98) step();
        chk("m_run", {busy, cnt_en}, 5'h15);
        spr_write(3'd0, 32'h505);
        chk("m_start_ign", {perf_start, busy, cnt_en}, 6'h15);
        spr_write(3'd0, 32'h506);
        chk("m_pend", {perf_end, cnt_en}, 5'h10);
        step();
        chk("m_settle", {done, irq}, 0);
        step();
        chk("m_done_irq", {done, irq}, 2'b11);
        repeat (5) step();
        chk("m_irq_hold", irq, 1);
        spr_write(3'd0, 32'h50C);
        chk("m_irq_clr", {done, irq}, 2'b10);

        // shadowed readout
        tc[128 +: 64] = 64'h0000_0001_FFFF_FFFF;
        tc[64 +: 64]  = 64'h1234_5678_9ABC_DEF0;
        spr_write(3'd3, 32'd2);
        spr_read(3'd3, rd);
        chk("sel_rb", rd, 2);
        spr_read(3'd4, rd);
        chk("lo_sel2", rd, 32'hFFFF_FFFF);
        tc[128 +: 64] = 64'h0000_0002_0000_0000;
        spr_read(3'd5, rd);
        chk("hi_shadow", rd, 32'h1);
        spr_read(3'd4, rd);
        chk("lo_sel2b", rd, 32'h0);
        spr_read(3'd5, rd);
        chk("hi_sel2b", rd, 32'h2);
        spr_write(3'd3, 32'd1);
        spr_read(3'd4, rd);
        chk("lo_sel1", rd, 32'h9ABC_DEF0);
        spr_read(3'd5, rd);
        chk("hi_sel1", rd, 32'h1234_5678);

        // boundary: WINDOW = 1, mask 0xF
        spr_write(3'd2, 32'd1);
        spr_write(3'd0, 32'hF01);
        chk("w1_pstart", perf_start, 1);
        step();
        chk("w1_run", cnt_en, 4'hF);
        step();
        chk("w1_pend", {perf_end, cnt_en}, 5'h10);
        repeat (2) step();
        chk("w1_done", done, 1);

        // reset during RUN
        spr_write(3'd2, 32'd0);
        spr_write(3'd0, 32'h501);
        repeat (4) step();
        chk("r_running", {busy, cnt_en}, 5'h15);
        rst = 1'b1;
        #1;
        chk("r_drop", {cnt_en, busy, done, perf_start, perf_end, irq}, 0);
        step();
        rst = 1'b0;
        spr_read(3'd1, rd);
        chk("r_status", rd, 0);
        spr_read(3'd0, rd);
        chk("r_ctrl", rd, 0);

        // start+stop together from IDLE
        spr_write(3'd0, 32'h503);
        chk("ss_nostart", {perf_start, busy}, 0);
        step();
        chk("ss_idle", {perf_start, busy, cnt_en}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
